// File: rtl/bp_mem_cmd_link_arbiter.sv
// bp_mem_cmd_link_arbiter
// Round-robin, packet-atomic arbiter that funnels num_req_p ready-and
// memory-command flit links onto one output link with zero added latency.
// A winner is picked on its header flit, and the grant stays locked until
// that packet's last flit has transferred. Packets are never interleaved.
//
// Optional build macro: BP_MEM_ARB_PERF_EN
//   When defined, the block adds pkt_cnt_o. This output holds one saturating
//   32-bit completed-packet counter per requester.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no lock; the round-robin winner is forwarded combinationally
// ST_LOCK    | grant held for owner_q until cnt_q body flits have transferred

module bp_mem_cmd_link_arbiter #(
   parameter int num_req_p    = 4,
   parameter int flit_width_p = 64,
   parameter int len_width_p  = 4,
   parameter int len_offset_p = 0,
   localparam int id_width_lp = $clog2(num_req_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_req_p*flit_width_p-1:0] data_i,
   input  logic [num_req_p-1:0]              v_i,
   output logic [num_req_p-1:0]              ready_and_o,
   output logic [flit_width_p-1:0]           data_o,
   output logic                              v_o,
   input  logic                              ready_and_i,
`ifdef BP_MEM_ARB_PERF_EN
   output logic [num_req_p*32-1:0]           pkt_cnt_o,
`endif
   output logic [id_width_lp-1:0]            grant_id_o
);

   typedef enum logic {
      ST_IDLE,
      ST_LOCK
   } state_e;

   state_e                   state_q;
   logic [id_width_lp-1:0]   owner_q;
   logic [len_width_p-1:0]   cnt_q;
   logic [id_width_lp-1:0]   rr_ptr_q;

   logic [id_width_lp-1:0]   winner;
   logic                     winner_found;
   int                       scan_idx;
   logic [id_width_lp-1:0]   sel;
   logic [len_width_p-1:0]   hdr_len;
   logic                     xfer;
   logic                     last_xfer;
   logic [id_width_lp-1:0]   rr_ptr_d;

   // Round-robin scan: the first valid requester at or above rr_ptr_q, with wrap-around
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      scan_idx     = 0;
      for (int i = 0; i < num_req_p; i++) begin
         scan_idx = (int'(rr_ptr_q) + i) % num_req_p;
         if (!winner_found && v_i[scan_idx]) begin
            winner       = id_width_lp'(scan_idx);
            winner_found = 1'b1;
         end
      end
   end

   // Output mux. Reset masks the handshake so nothing can transfer while reset_i is high.
   always_comb begin
      sel         = (state_q == ST_LOCK) ? owner_q : winner;
      data_o      = data_i[sel*flit_width_p +: flit_width_p];
      v_o         = 1'b0;
      ready_and_o = '0;
      if (!reset_i) begin
         v_o              = (state_q == ST_LOCK) ? v_i[owner_q] : (|v_i);
         ready_and_o[sel] = ready_and_i;
      end
      grant_id_o = sel;
   end

   // Transfer detection, header length, and end-of-packet detection
   always_comb begin
      hdr_len   = data_o[len_offset_p +: len_width_p];
      xfer      = v_o & ready_and_i;
      last_xfer = 1'b0;
      if (xfer) begin
         if (state_q == ST_IDLE)
            last_xfer = (hdr_len == '0);
         else
            last_xfer = (cnt_q == len_width_p'(1));
      end
      rr_ptr_d = (sel == id_width_lp'(num_req_p - 1)) ? '0 : sel + id_width_lp'(1);
   end

   // Lock FSM: header capture, body flit countdown, and round-robin pointer update
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  if (hdr_len == '0) begin
                     rr_ptr_q <= rr_ptr_d;
                  end else begin
                     state_q <= ST_LOCK;
                     owner_q <= winner;
                     cnt_q   <= hdr_len;
                  end
               end
            end
            ST_LOCK: begin
               if (xfer) begin
                  cnt_q <= cnt_q - len_width_p'(1);
                  if (cnt_q == len_width_p'(1)) begin
                     state_q  <= ST_IDLE;
                     rr_ptr_q <= rr_ptr_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef BP_MEM_ARB_PERF_EN
   logic [31:0] pkt_cnt_q [num_req_p];

   for (genvar k = 0; k < num_req_p; k++) begin : g_perf
      // Saturating per-requester completed-packet counter
      always_ff @(posedge clk_i) begin
         if (reset_i)
            pkt_cnt_q[k] <= '0;
         else if (last_xfer && (sel == id_width_lp'(k)) && (pkt_cnt_q[k] != 32'hFFFF_FFFF))
            pkt_cnt_q[k] <= pkt_cnt_q[k] + 32'd1;
      end
      assign pkt_cnt_o[k*32 +: 32] = pkt_cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_bp_mem_cmd_link_arbiter.sv
// Directed testbench for bp_mem_cmd_link_arbiter with num_req_p = 4, 64-bit flits,
// and a 4-bit length field at bit 0.
// Requester k drives flit {48'h0, 8'(k), 4'h0, len_k}. The data_o id byte and
// len nibble therefore identify which requester's slice is being forwarded.

module tb_bp_mem_cmd_link_arbiter;

   localparam int N = 4;
   localparam int W = 64;

   logic             clk = 1'b0;
   logic             reset_i;
   logic [N*W-1:0]   data_i;
   logic [N-1:0]     v_i;
   logic [N-1:0]     ready_and_o;
   logic [W-1:0]     data_o;
   logic             v_o;
   logic             ready_and_i;
   logic [1:0]       grant_id_o;
`ifdef BP_MEM_ARB_PERF_EN
   logic [N*32-1:0]  pkt_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bp_mem_cmd_link_arbiter #(
      .num_req_p(N), .flit_width_p(W), .len_width_p(4), .len_offset_p(0)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .data_i(data_i),
      .v_i(v_i),
      .ready_and_o(ready_and_o),
      .data_o(data_o),
      .v_o(v_o),
      .ready_and_i(ready_and_i),
`ifdef BP_MEM_ARB_PERF_EN
      .pkt_cnt_o(pkt_cnt_o),
`endif
      .grant_id_o(grant_id_o)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic        rdy;
      logic [15:0] lens;   // len of requester k in [4k +: 4]
      logic        ev;
      logic [3:0]  erdy;
      logic [1:0]  egid;
      logic        cg;     // check grant id and forwarded data
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] v, input logic rdy,
                      input logic [15:0] lens, input logic ev, input logic [3:0] erdy,
                      input logic [1:0] egid, input logic cg);
      vec_t t;
      t.rst = rst; t.v = v; t.rdy = rdy; t.lens = lens;
      t.ev = ev; t.erdy = erdy; t.egid = egid; t.cg = cg;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs just after a falling edge. The caller samples the combinational outputs before the next rising edge.
   task automatic drive(input logic rst, input logic [3:0] v, input logic rdy, input logic [15:0] lens);
      @(negedge clk);
      reset_i     = rst;
      v_i         = v;
      ready_and_i = rdy;
      for (int k = 0; k < N; k++)
         data_i[k*W +: W] = {48'h0, 8'(k), 4'h0, lens[4*k +: 4]};
      #1;
   endtask

   task automatic check_out(input string tag, input logic ev, input logic [3:0] erdy,
                            input logic [1:0] egid, input logic cg, input logic [15:0] lens);
      logic [3:0] elen;
      chk({tag, ".v_o"}, 64'(v_o), 64'(ev));
      chk({tag, ".ready_and_o"}, 64'(ready_and_o), 64'(erdy));
      if (cg) begin
         elen = lens[4*egid +: 4];
         chk({tag, ".grant_id_o"}, 64'(grant_id_o), 64'(egid));
         chk({tag, ".data_o.id"}, 64'(data_o[15:8]), 64'(egid));
         chk({tag, ".data_o.len"}, 64'(data_o[3:0]), 64'(elen));
      end
   endtask

   initial begin
      reset_i     = 1'b1;
      v_i         = '1;
      ready_and_i = 1'b1;
      data_i      = '0;

      // Reset held for 3 cycles with every input active.
      for (int i = 0; i < 3; i++) add(1, 4'hF, 1, 16'h0000, 0, 4'h0, 0, 0);
      // Round robin with single-flit packets: the grant sequence is 0,1,2,3,0,1. rr ends at 2.
      add(0, 4'hF, 1, 16'h0000, 1, 4'b0001, 0, 1);
      add(0, 4'hF, 1, 16'h0000, 1, 4'b0010, 1, 1);
      add(0, 4'hF, 1, 16'h0000, 1, 4'b0100, 2, 1);
      add(0, 4'hF, 1, 16'h0000, 1, 4'b1000, 3, 1);
      add(0, 4'hF, 1, 16'h0000, 1, 4'b0001, 0, 1);
      add(0, 4'hF, 1, 16'h0000, 1, 4'b0010, 1, 1);
      // Walk rr to 1: single-flit packets from requesters 2, 3, and 0.
      add(0, 4'b0100, 1, 16'h0000, 1, 4'b0100, 2, 1);
      add(0, 4'b1000, 1, 16'h0000, 1, 4'b1000, 3, 1);
      add(0, 4'b0001, 1, 16'h0000, 1, 4'b0001, 0, 1);
      // Atomicity: requester 1 sends len=3 (4 flits) while requester 2 stays valid.
      for (int i = 0; i < 4; i++) add(0, 4'b0110, 1, 16'h0030, 1, 4'b0010, 1, 1);
      add(0, 4'b0110, 1, 16'h0030, 1, 4'b0100, 2, 1);
      // rr is now 3. Requester 3 sends a single flit, so rr becomes 0.
      add(0, 4'b1000, 1, 16'h0000, 1, 4'b1000, 3, 1);
      // Backpressure and bubble: requester 0 sends len=2 while requester 3 is valid.
      add(0, 4'b1001, 1, 16'h0002, 1, 4'b0001, 0, 1); // header
      add(0, 4'b1001, 0, 16'h0002, 1, 4'b0000, 0, 1); // downstream stall
      add(0, 4'b1001, 1, 16'h0002, 1, 4'b0001, 0, 1); // body 1
      add(0, 4'b1000, 1, 16'h0002, 0, 4'b0001, 0, 1); // owner bubble: lock holds
      add(0, 4'b1001, 1, 16'h0002, 1, 4'b0001, 0, 1); // final flit
      add(0, 4'b1001, 1, 16'h0002, 1, 4'b1000, 3, 1); // back-to-back: 3 wins at once

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].rdy, vecs[i].lens);
         check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].egid,
                   vecs[i].cg, vecs[i].lens);
      end
      // The last vector sent a single flit from 3, so rr is now 0.

      // Mid-packet reset: requester 2 sends len=5, and reset is asserted after 2 flits.
      drive(0, 4'b0100, 1, 16'h0500);
      check_out("mr_hdr", 1, 4'b0100, 2, 1, 16'h0500);
      drive(0, 4'b0101, 1, 16'h0500);
      check_out("mr_body1", 1, 4'b0100, 2, 1, 16'h0500);
      drive(1, 4'b0101, 1, 16'h0500);
      check_out("mr_rst", 0, 4'b0000, 0, 0, 16'h0500);
      drive(0, 4'b0101, 1, 16'h0500);
      check_out("mr_after", 1, 4'b0001, 0, 1, 16'h0500);
      drive(0, 4'b0101, 1, 16'h0500);
      check_out("mr_next", 1, 4'b0100, 2, 1, 16'h0500);

`ifdef BP_MEM_ARB_PERF_EN
      // Performance counters: 5 packets from requester 1 and 2 packets from requester 3.
      drive(1, 4'b0000, 1, 16'h0000);
      for (int i = 0; i < 5; i++) drive(0, 4'b0010, 1, 16'h0000);
      for (int i = 0; i < 4; i++) drive(0, 4'b1000, 1, 16'h1000);
      drive(0, 4'b0000, 1, 16'h0000);
      chk("pkt_cnt0", 64'(pkt_cnt_o[0  +: 32]), 64'd0);
      chk("pkt_cnt1", 64'(pkt_cnt_o[32 +: 32]), 64'd5);
      chk("pkt_cnt2", 64'(pkt_cnt_o[64 +: 32]), 64'd0);
      chk("pkt_cnt3", 64'(pkt_cnt_o[96 +: 32]), 64'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
